uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` byte interface among `NUM_REQ` byte-stream requesters, such as a banner generator, an rx echo path and a status reporter. Arbitration is packet-locked: once a requester is granted, it keeps the transmitter until it presents a byte flagged `last`, or until it stalls past a timeout. The block sits between the requesters and `uart_tx` inside the UART top level. It owns the transmitter's `tx_data`/`tx_data_valid` inputs through a single registered output stage.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 50_000: idle cycles a granted requester may stall before losing grant (1 ms at 50 MHz); 0 disables the timeout.
- `clk`  in  1  system clock (50 MHz).
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `req_data`  in  NUM_REQ*8  byte of requester i at bits [i*8 +: 8].
- `req_valid`  in  NUM_REQ  requester i has a byte.
- `req_last`  in  NUM_REQ  byte of requester i ends its packet.
- `req_ready`  out  NUM_REQ  byte of requester i accepted this cycle when `valid` is also high.
- `tx_data`  out  8  byte to `uart_tx`.
- `tx_data_valid`  out  1  to `uart_tx`.
- `tx_data_ready`  in  1  from `uart_tx`.
- `grant`  out  NUM_REQ  one-hot current owner; 0 when idle.
- `busy`  out  1  high in LOCK or while `tx_data_valid` is high.

## Operation
- States:
  - IDLE: no owner.
  - LOCK: owner `g` holds the transmitter.
- IDLE transitions:
  - If any `req_valid` is high, pick the first set bit scanning from `rr_ptr+1` upward, mod NUM_REQ.
  - Set `grant` one-hot to the pick, set `rr_ptr` to the pick, go to LOCK.
  - No byte is accepted in IDLE.
- Output register behaviour:
  - `out_free = !tx_data_valid || tx_data_ready`.
  - In LOCK, `req_ready[g] = out_free`; every other `req_ready` bit is 0. `req_ready` is all 0 in IDLE.
  - Accept (`req_valid[g] && req_ready[g]`): `tx_data <= req_data[g]`, `tx_data_valid <= 1`.
  - `tx_data_ready` with no accept: `tx_data_valid <= 0`.
  - `tx_data` is held stable while `tx_data_valid` is high and `tx_data_ready` is low.
- LOCK exit on last: accept with `req_last[g]` → `grant <= 0`, go to IDLE. The last byte drains from the output register independently.
- Timeout:
  - `stall_cnt` (32-bit) clears on entering LOCK and on every accept.
  - It increments each LOCK cycle with `req_valid[g]` low.
  - When `TIMEOUT != 0` and `stall_cnt == TIMEOUT-1` with no accept, go to IDLE and set `grant <= 0`.
  - The partially sent packet is abandoned, not rolled back.
- Simultaneous events:
  - A last-accept and a new request in the same cycle: the new request is granted in the following IDLE cycle, never in the same cycle.
  - A `tx_data_ready` pop and an accept in the same cycle: the new byte loads and `tx_data_valid` stays 1.
- Requester `req_valid` may drop mid-packet; the grant is retained until `last` or timeout.
- Reset mid-packet: all state clears immediately and the byte in flight is dropped. `uart_tx` shares `rst_n`.

## Timing
- Reset values: `tx_data` = 0, `tx_data_valid` = 0, `grant` = 0, `req_ready` = 0, `busy` = 0, `rr_ptr` = NUM_REQ-1 (requester 0 wins first), state = IDLE.
- Latency from `req_valid` rising in IDLE:
  - cycle 1: `grant` set.
  - cycle 1: `req_ready` high when the output register is free.
  - cycle 2: `tx_data_valid` high.
- Throughput: one byte per `tx_data_ready` pulse with no bubble while the owner keeps `req_valid` high. `req_ready` depends combinationally on `tx_data_ready`.
- Packet gap: 1 IDLE cycle between consecutive packets.
- The timeout fires exactly TIMEOUT stalled cycles after the last accept.

## Structure
- Shared package `uart_pkg`:
  - state constants `ARB_IDLE` = 0, `ARB_LOCK` = 1;
  - `CLK_FRE` = 50, `UART_FRE` = 115200;
  - default `TIMEOUT`.
- Sub-module `uart_rr_pick`, combinational:
  - inputs `req[NUM_REQ]`, `ptr`;
  - outputs `pick_oh[NUM_REQ]`, `pick_idx`, `any`.
- The remainder (FSM, output register, stall counter) lives in `uart_tx_arbiter`.

## Test plan
- Single requester 0 sends 3 bytes 0x41, 0x42, 0x43 (last on 0x43) with `tx_data_ready` pulsing every 10 cycles → `uart_tx` receives 0x41, 0x42, 0x43 in order; `grant` = 4'b0001 then 0; `tx_data_valid` first rises 2 cycles after `req_valid`.
- All 4 requesters valid continuously with 2-byte packets → packet order 0, 1, 2, 3, 0; bytes never interleave within a packet; 1 idle cycle between packets.
- `tx_data_ready` held low 100 cycles while a byte is pending → `tx_data` is stable, `req_ready` = 0, and no accept occurs.
- `TIMEOUT` = 16; requester 2 sends 1 byte without last, then drops valid → `grant` clears exactly 16 cycles after the accept; pending requester 3 is granted on the next cycle.
- `rst_n` pulsed low mid-packet with `tx_data_valid` = 1 → all outputs go to 0 asynchronously; after release, requester 0 has priority.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART top level: clocking, arbiter state encoding
// and the default stall timeout of the transmit arbiter.
package uart_pkg;

  localparam int CLK_FRE  = 50;
  localparam int UART_FRE = 115200;

  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_LOCK = 1'b1;

  // 1 ms at 50 MHz
  localparam int ARB_TIMEOUT = 50_000;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin pick: first set request bit scanning upward from
// ptr+1, wrapping modulo NUM_REQ.
module uart_rr_pick import uart_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick_oh,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               any
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    any      = 1'b0;
    idx      = '0;
    // i = NUM_REQ lands back on ptr itself, so the previous owner is scanned last
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!any && req[idx]) begin
        any          = 1'b1;
        pick_idx     = idx;
        pick_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one uart_tx byte interface among
// NUM_REQ requesters, with a single registered output stage and stall timeout.
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_data_valid,
  input  logic                 tx_data_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic [0:0]           state_dbg
);

  localparam int          IDX_W     = $clog2(NUM_REQ);
  localparam logic [31:0] STALL_LIM = 32'(TIMEOUT - 1);

  // Handshakes: a byte moves on any edge where valid && ready are both high;
  // valid must not depend on ready, and data is held while valid waits.
  logic [0:0]         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic               pick_any;
  logic [31:0]        stall_cnt;
  logic               out_free;
  logic               accept;
  logic               owner_valid;
  logic               owner_last;
  logic [7:0]         owner_data;
  logic               timeout_hit;

  uart_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  // rr_ptr doubles as the owner index while in LOCK
  assign owner_valid = req_valid[rr_ptr];
  assign owner_last  = req_last[rr_ptr];
  assign owner_data  = req_data[{rr_ptr, 3'b000} +: 8];

  assign out_free    = !tx_data_valid || tx_data_ready;
  assign accept      = (state == ARB_LOCK) && owner_valid && out_free;
  assign timeout_hit = (TIMEOUT != 0) && (stall_cnt == STALL_LIM) && !accept;
  assign busy        = (state == ARB_LOCK) || tx_data_valid;
  assign state_dbg   = state;

  always_comb begin
    req_ready = '0;
    if (state == ARB_LOCK && out_free) req_ready[rr_ptr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      grant     <= '0;
      rr_ptr    <= IDX_W'(NUM_REQ - 1);
      stall_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            grant     <= pick_oh;
            rr_ptr    <= pick_idx;
            stall_cnt <= '0;
            state     <= ARB_LOCK;
          end
        end
        default: begin
          if (accept) begin
            stall_cnt <= '0;
            if (owner_last) begin
              grant <= '0;
              state <= ARB_IDLE;
            end
          end else if (timeout_hit) begin
            // abandon the partial packet; nothing already sent is recalled
            grant <= '0;
            state <= ARB_IDLE;
          end else if (!owner_valid) begin
            stall_cnt <= stall_cnt + 32'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data       <= '0;
      tx_data_valid <= 1'b0;
    end else if (accept) begin
      tx_data       <= owner_data;
      tx_data_valid <= 1'b1;
    end else if (tx_data_ready) begin
      tx_data_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues, a uart_tx sink with a
// byte scoreboard, and one task per scenario.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NR = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR*8-1:0] req_data = '0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_last = '0;
  logic [NR-1:0]   req_ready;
  logic [7:0]      tx_data;
  logic            tx_data_valid;
  logic            tx_data_ready = 1'b0;
  logic [NR-1:0]   grant;
  logic            busy;
  logic [0:0]      state_dbg;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_data      (req_data),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .grant         (grant),
    .busy          (busy),
    .state_dbg     (state_dbg)
  );

  typedef struct {
    int   idx;
    int   cyc;
    logic last;
  } acc_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          ready_mode = 0;
  logic [NR-1:0] en = '0;
  logic [8:0]  rq[NR][$];
  logic [7:0]  exp_q[$];
  acc_t        acc_log[$];

  // ---------------- driver tasks ----------------
  task automatic drive_reqs();
    logic [8:0] w;
    for (int i = 0; i < NR; i++) begin
      if (en[i] && rq[i].size() > 0) begin
        w = rq[i][0];
        req_valid[i]       = 1'b1;
        req_data[i*8 +: 8] = w[7:0];
        req_last[i]        = w[8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic update_ready();
    case (ready_mode)
      0:       tx_data_ready = 1'b1;
      1:       tx_data_ready = (cyc % 10 == 0);
      default: tx_data_ready = 1'b0;
    endcase
  endtask

  task automatic set_mode(input int m);
    ready_mode = m;
    update_ready();
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input logic last);
    rq[r].push_back({last, d});
    exp_q.push_back(d);
  endtask

  // One clock: handshakes sampled at negedge, inputs updated at posedge+1,
  // returns at posedge+2 with combinational outputs settled.
  task automatic tick();
    logic [NR-1:0] acc_mask;
    logic [7:0]    e;
    acc_t          a;
    @(negedge clk);
    acc_mask = req_valid & req_ready;
    if (tx_data_valid && tx_data_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard: unexpected byte %02h, expected none", tx_data);
      end else begin
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          n_fail++;
          $display("FAIL scoreboard: tx_data %02h, expected %02h", tx_data, e);
        end
      end
    end
    for (int i = 0; i < NR; i++) begin
      if (acc_mask[i]) begin
        a.idx = i; a.cyc = cyc; a.last = req_last[i];
        acc_log.push_back(a);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NR; i++)
      if (acc_mask[i]) void'(rq[i].pop_front());
    update_ready();
    drive_reqs();
    #1;
  endtask

  function automatic bit all_empty();
    bit r = 1'b1;
    for (int i = 0; i < NR; i++)
      if (rq[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic drain(input int max_cycles, input string name);
    int n = 0;
    while (!(all_empty() && !tx_data_valid) && n < max_cycles) begin
      tick();
      n++;
    end
    tick();
    n_checks++;
    if (!all_empty() || tx_data_valid || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s drain: %0d bytes still expected after %0d cycles, expected 0",
               name, exp_q.size(), n);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    en = '0;
    for (int i = 0; i < NR; i++) rq[i].delete();
    exp_q.delete();
    acc_log.delete();
    ready_mode = 0;
    tx_data_ready = 1'b0;
    drive_reqs();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (tx_data !== 8'h00 || tx_data_valid !== 1'b0 || grant !== 4'b0000 ||
        req_ready !== 4'b0000 || busy !== 1'b0 || state_dbg !== ARB_IDLE) begin
      n_fail++;
      $display("FAIL reset_values: data=%02h v=%b g=%b rdy=%b busy=%b st=%b, expected 00 0 0000 0000 0 0",
               tx_data, tx_data_valid, grant, req_ready, busy, state_dbg);
    end
  endtask

  task automatic test_single();
    int n = 0;
    logic [NR-1:0] exp_g;
    apply_reset();
    set_mode(1);
    push_byte(0, 8'h41, 1'b0);
    push_byte(0, 8'h42, 1'b0);
    push_byte(0, 8'h43, 1'b1);
    en[0] = 1'b1;
    drive_reqs();
    tick();
    n_checks++;
    if (grant !== 4'b0001 || req_ready !== 4'b0001 || tx_data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_cycle1: grant=%b ready=%b v=%b, expected 0001 0001 0",
               grant, req_ready, tx_data_valid);
    end
    tick();
    n_checks++;
    if (tx_data_valid !== 1'b1 || tx_data !== 8'h41) begin
      n_fail++;
      $display("FAIL single_cycle2: v=%b data=%02h, expected 1 41", tx_data_valid, tx_data);
    end
    while (!(rq[0].size() == 0 && !tx_data_valid) && n < 200) begin
      tick();
      n++;
      exp_g = (rq[0].size() > 0) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (grant !== exp_g) begin
        n_fail++;
        $display("FAIL single_grant: grant=%b, expected %b", grant, exp_g);
      end
    end
    drain(50, "single");
    n_checks++;
    if (busy !== 1'b0 || grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_idle: busy=%b grant=%b, expected 0 0000", busy, grant);
    end
  endtask

  task automatic test_back_to_back();
    int exp_idx[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int exp_gap;
    int n = 0;
    apply_reset();
    set_mode(0);
    push_byte(0, 8'h00, 1'b0);
    push_byte(0, 8'h01, 1'b1);
    push_byte(1, 8'h10, 1'b0);
    push_byte(1, 8'h11, 1'b1);
    push_byte(2, 8'h20, 1'b0);
    push_byte(2, 8'h21, 1'b1);
    push_byte(3, 8'h30, 1'b0);
    push_byte(3, 8'h31, 1'b1);
    push_byte(0, 8'h02, 1'b0);
    push_byte(0, 8'h03, 1'b1);
    en = '1;
    drive_reqs();
    while (!all_empty() && n < 200) begin
      tick();
      n++;
    end
    drain(20, "b2b");
    n_checks++;
    if (acc_log.size() != 10) begin
      n_fail++;
      $display("FAIL b2b_count: %0d accepts, expected 10", acc_log.size());
    end
    for (int k = 0; k < acc_log.size() && k < 10; k++) begin
      n_checks++;
      if (acc_log[k].idx != exp_idx[k]) begin
        n_fail++;
        $display("FAIL b2b_order[%0d]: requester %0d, expected %0d", k, acc_log[k].idx, exp_idx[k]);
      end
      if (k > 0) begin
        exp_gap = acc_log[k-1].last ? 2 : 1;
        n_checks++;
        if (acc_log[k].cyc - acc_log[k-1].cyc != exp_gap) begin
          n_fail++;
          $display("FAIL b2b_gap[%0d]: %0d cycles, expected %0d", k,
                   acc_log[k].cyc - acc_log[k-1].cyc, exp_gap);
        end
      end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    set_mode(2);
    push_byte(0, 8'h55, 1'b0);
    push_byte(0, 8'h66, 1'b1);
    en[0] = 1'b1;
    drive_reqs();
    tick();
    tick();
    n_checks++;
    if (tx_data_valid !== 1'b1 || tx_data !== 8'h55) begin
      n_fail++;
      $display("FAIL stall_load: v=%b data=%02h, expected 1 55", tx_data_valid, tx_data);
    end
    for (int k = 0; k < 100; k++) begin
      tick();
      n_checks++;
      if (tx_data !== 8'h55 || tx_data_valid !== 1'b1 || req_ready !== 4'b0000 ||
          acc_log.size() != 1) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: data=%02h v=%b ready=%b accepts=%0d, expected 55 1 0000 1",
                 k, tx_data, tx_data_valid, req_ready, acc_log.size());
      end
    end
    set_mode(0);
    drain(50, "stall");
  endtask

  task automatic test_timeout();
    logic [NR-1:0] exp_g;
    apply_reset();
    set_mode(0);
    push_byte(2, 8'hA0, 1'b0);
    push_byte(3, 8'hB0, 1'b1);
    en[2] = 1'b1;
    en[3] = 1'b1;
    drive_reqs();
    tick();
    n_checks++;
    if (grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL timeout_grant2: grant=%b, expected 0100", grant);
    end
    tick();
    n_checks++;
    if (acc_log.size() != 1 || tx_data !== 8'hA0) begin
      n_fail++;
      $display("FAIL timeout_accept: accepts=%0d data=%02h, expected 1 A0", acc_log.size(), tx_data);
    end
    for (int k = 1; k <= TO; k++) begin
      tick();
      exp_g = (k < TO) ? 4'b0100 : 4'b0000;
      n_checks++;
      if (grant !== exp_g) begin
        n_fail++;
        $display("FAIL timeout_hold[%0d]: grant=%b, expected %b", k, grant, exp_g);
      end
    end
    tick();
    n_checks++;
    if (grant !== 4'b1000) begin
      n_fail++;
      $display("FAIL timeout_next: grant=%b, expected 1000", grant);
    end
    drain(50, "timeout");
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    set_mode(2);
    push_byte(0, 8'h77, 1'b0);
    push_byte(0, 8'h78, 1'b1);
    en[0] = 1'b1;
    drive_reqs();
    tick();
    tick();
    n_checks++;
    if (tx_data_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_pre: v=%b busy=%b, expected 1 1", tx_data_valid, busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (tx_data !== 8'h00 || tx_data_valid !== 1'b0 || grant !== 4'b0000 ||
        req_ready !== 4'b0000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_async: data=%02h v=%b g=%b rdy=%b busy=%b, expected 00 0 0000 0000 0",
               tx_data, tx_data_valid, grant, req_ready, busy);
    end
    en = '0;
    for (int i = 0; i < NR; i++) rq[i].delete();
    exp_q.delete();
    acc_log.delete();
    drive_reqs();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    set_mode(0);
    push_byte(0, 8'h81, 1'b1);
    push_byte(1, 8'h91, 1'b1);
    en[0] = 1'b1;
    en[1] = 1'b1;
    drive_reqs();
    tick();
    n_checks++;
    if (grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL midreset_priority: grant=%b, expected 0001", grant);
    end
    drain(50, "midreset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_timeout();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
